// File: rtl/user_input_conditioner.sv
// Purpose : front end of the washing controller; synchronizes and debounces raw panel
//           buttons, switches and the occupancy sensor, generates the ce time base and
//           turns button presses into reg_* request levels held in step with controller status.
// Latency : raw input to debounced level 2+DB_CYCLES cycles; request outputs are
//           registered one cycle after the FSM decision.
// Flow    : no backpressure; requests are held until stt_using acknowledges or releases them.
// Ports   : clk, reset (sync, active-high); btn_user, btn_spray, sns_wash_using and
//           sw_* raw asynchronous inputs; stt_ready/stt_using controller status;
//           ce time-base pulse; reg_* request and config levels to the controller.
// Option  : define USER_TIMEOUT_EN to let a pending user request expire after USER_TIMEOUT ce ticks.
module user_input_conditioner #(
  parameter int CE_DIV       = 1000000,
  parameter int DB_CYCLES    = 20000,
  parameter int USER_TIMEOUT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_user,
  input  logic btn_spray,
  input  logic sns_wash_using,
  input  logic sw_sp_dr_auto,
  input  logic sw_spray_mode,
  input  logic sw_auto_dis,
  input  logic sw_de_ur,
  input  logic stt_ready,
  input  logic stt_using,
  output logic ce,
  output logic reg_user_en,
  output logic reg_wash_using,
  output logic reg_spray_en,
  output logic reg_sp_dr_auto_en,
  output logic reg_spray_mode,
  output logic reg_auto_dis_en,
  output logic reg_de_ur
);

  localparam int NIN  = 7;
  localparam int CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_USER_PEND,
    REQ_IN_USE,
    REQ_FLUSH_PEND
  } req_state_t;

  // bit 0 user, 1 spray, 2 occupancy, 3..6 config switches
  logic [NIN-1:0]  w_raw;
  logic [NIN-1:0]  r_sync1;
  logic [NIN-1:0]  r_sync2;
  logic [NIN-1:0]  r_deb;
  logic [DB_W-1:0] r_db_cnt [NIN];
  logic [1:0]      r_btn_prev;
  logic [CE_W-1:0] r_ce_cnt;
  logic            r_ce;
  logic [3:0]      r_cfg;
  req_state_t      r_state;
  req_state_t      w_state_nxt;
  logic            r_user_en;
  logic            r_spray_en;
  logic            w_user_press;
  logic            w_spray_press;
  logic            w_to_hit;

  assign w_raw = {sw_de_ur, sw_auto_dis, sw_spray_mode, sw_sp_dr_auto,
                  sns_wash_using, btn_spray, btn_user};

  // Two-flop synchronizer followed by one debounce counter per input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NIN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          // mismatch has now persisted DB_CYCLES cycles: accept the new level
          r_deb[i]    <= ~r_deb[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // One press event per rising edge of a debounced button.
  always_ff @(posedge clk) begin
    if (reset) r_btn_prev <= '0;
    else       r_btn_prev <= r_deb[1:0];
  end

  assign w_user_press  = r_deb[0] & ~r_btn_prev[0];
  assign w_spray_press = r_deb[1] & ~r_btn_prev[1];

  // Free-running time base; ce is registered so it rises CE_DIV cycles after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ce_cnt <= '0;
      r_ce     <= 1'b0;
    end else begin
      r_ce <= (r_ce_cnt == CE_W'(CE_DIV - 1));
      if (r_ce_cnt == CE_W'(CE_DIV - 1)) r_ce_cnt <= '0;
      else                               r_ce_cnt <= r_ce_cnt + CE_W'(1);
    end
  end

  // Config follows the switches only while the controller is idle, frozen for a wash cycle.
  always_ff @(posedge clk) begin
    if (reset)          r_cfg <= '0;
    else if (stt_ready) r_cfg <= r_deb[6:3];
  end

`ifdef USER_TIMEOUT_EN
  localparam int TO_W = $clog2(USER_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts ce ticks spent waiting in REQ_USER_PEND; zero whenever idle so each request starts fresh.
  always_ff @(posedge clk) begin
    if (reset || r_state == REQ_IDLE) begin
      r_to_cnt <= '0;
    end else if (r_state == REQ_USER_PEND && !stt_using && r_ce &&
                 r_to_cnt != TO_W'(USER_TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_to_hit = r_ce && (r_to_cnt == TO_W'(USER_TIMEOUT - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= REQ_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ_IDLE:       if (w_user_press && stt_ready) w_state_nxt = REQ_USER_PEND;
      // stt_using is tested first so it wins over a simultaneous timeout
      REQ_USER_PEND:  if (stt_using)      w_state_nxt = REQ_IN_USE;
                      else if (w_to_hit)  w_state_nxt = REQ_IDLE;
      // leaving use takes priority over a spray press in the same cycle
      REQ_IN_USE:     if (!stt_using)     w_state_nxt = REQ_IDLE;
                      else if (w_spray_press) w_state_nxt = REQ_FLUSH_PEND;
      REQ_FLUSH_PEND: if (!stt_using)     w_state_nxt = REQ_IDLE;
      default:        w_state_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_user_en  <= 1'b0;
      r_spray_en <= 1'b0;
    end else begin
      r_user_en  <= (w_state_nxt == REQ_USER_PEND);
      r_spray_en <= (w_state_nxt == REQ_FLUSH_PEND);
    end
  end

  assign ce                = r_ce;
  assign reg_user_en       = r_user_en;
  assign reg_spray_en      = r_spray_en;
  assign reg_wash_using    = r_deb[2];
  assign reg_sp_dr_auto_en = r_cfg[0];
  assign reg_spray_mode    = r_cfg[1];
  assign reg_auto_dis_en   = r_cfg[2];
  assign reg_de_ur         = r_cfg[3];

endmodule

// File: tb/tb_user_input_conditioner.sv
// Purpose : bench for user_input_conditioner with CE_DIV=10, DB_CYCLES=4, USER_TIMEOUT=3.
// Latency : outputs sampled on the falling edge, inputs driven on the falling edge.
// Flow    : a windowed reference model runs alongside the design and is compared per scenario.
module tb_user_input_conditioner;

  localparam int P_CE = 10;
  localparam int P_DB = 4;
  localparam int P_TO = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] raw;
  logic       stt_ready;
  logic       stt_using;
  logic       ce;
  logic       reg_user_en;
  logic       reg_wash_using;
  logic       reg_spray_en;
  logic       reg_sp_dr_auto_en;
  logic       reg_spray_mode;
  logic       reg_auto_dis_en;
  logic       reg_de_ur;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_input_conditioner #(.CE_DIV(P_CE), .DB_CYCLES(P_DB), .USER_TIMEOUT(P_TO)) dut (
    .clk(clk), .reset(reset),
    .btn_user(raw[0]), .btn_spray(raw[1]), .sns_wash_using(raw[2]),
    .sw_sp_dr_auto(raw[3]), .sw_spray_mode(raw[4]), .sw_auto_dis(raw[5]), .sw_de_ur(raw[6]),
    .stt_ready(stt_ready), .stt_using(stt_using),
    .ce(ce), .reg_user_en(reg_user_en), .reg_wash_using(reg_wash_using),
    .reg_spray_en(reg_spray_en), .reg_sp_dr_auto_en(reg_sp_dr_auto_en),
    .reg_spray_mode(reg_spray_mode), .reg_auto_dis_en(reg_auto_dis_en), .reg_de_ur(reg_de_ur)
  );

  logic [7:0] obs;
  logic [3:0] obs_cfg;
  assign obs = {ce, reg_user_en, reg_wash_using, reg_spray_en,
                reg_sp_dr_auto_en, reg_spray_mode, reg_auto_dis_en, reg_de_ur};
  assign obs_cfg = {reg_de_ur, reg_auto_dis_en, reg_spray_mode, reg_sp_dr_auto_en};

  // Reference model: an input level is accepted once the synchronized value has
  // disagreed with the accepted level for the last DB_CYCLES edges in a row.
  logic [6:0] m_d0 = '0, m_d1 = '0, m_deb = '0, m_prev = '0, m_sync;
  logic [6:0] m_win [P_DB];
  logic       m_ce = 1'b0, m_pu, m_ps, m_alldiff;
  logic [3:0] m_cfg = '0;
  int         m_cyc = 0, m_mode = 0, m_to = 0;  // mode: 0 idle, 1 user pending, 2 in use, 3 flush
  logic [7:0] m_exp;
  assign m_exp = {m_ce, (m_mode == 1), m_deb[2], (m_mode == 3),
                  m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]};

  always @(posedge clk) begin
    if (reset) begin
      m_d0 = '0; m_d1 = '0; m_deb = '0; m_prev = '0;
      for (int k = 0; k < P_DB; k++) m_win[k] = '0;
      m_ce = 1'b0; m_cfg = '0; m_cyc = 0; m_mode = 0; m_to = 0;
    end else begin
      m_pu = m_deb[0] & ~m_prev[0];
      m_ps = m_deb[1] & ~m_prev[1];
      case (m_mode)
        0: if (m_pu && stt_ready) begin m_mode = 1; m_to = 0; end
        1: begin
          if (stt_using) m_mode = 2;
`ifdef USER_TIMEOUT_EN
          else if (m_ce) begin
            m_to = m_to + 1;
            if (m_to >= P_TO) m_mode = 0;
          end
`endif
        end
        2: if (!stt_using) m_mode = 0; else if (m_ps) m_mode = 3;
        default: if (!stt_using) m_mode = 0;
      endcase
      if (stt_ready) m_cfg = m_deb[6:3];
      m_prev = m_deb;
      m_sync = m_d1; m_d1 = m_d0; m_d0 = raw;
      for (int k = P_DB - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_sync;
      for (int i = 0; i < 7; i++) begin
        m_alldiff = 1'b1;
        for (int k = 0; k < P_DB; k++) if (m_win[k][i] == m_deb[i]) m_alldiff = 1'b0;
        if (m_alldiff) m_deb[i] = ~m_deb[i];
      end
      m_cyc = m_cyc + 1;
      m_ce  = (m_cyc % P_CE == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; raw = 7'($urandom); stt_ready = 1'b1; stt_using = 1'b1;
    tick(3);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00); end
    raw = '0; stt_ready = 1'b0; stt_using = 1'b0; reset = 1'b0;
  endtask

  task automatic test_ce;
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (ce === 1'b1) pulses++;
      checks++;
      if (ce !== (k % P_CE == 0)) begin
        errors++; $display("FAIL ce_cadence cycle=%0d got=%b want=%b", k, ce, (k % P_CE == 0));
      end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL ce_count got=%0d want=4", pulses); end
  endtask

  task automatic test_debounce;
    int seen = 0;
    stt_ready = 1'b1;
    raw[0] = 1'b1; tick(3); raw[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(1); if (reg_user_en !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL glitch_rejected high_cycles=%0d want=0", seen); end
    raw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      checks++;
      if (reg_user_en !== (k == 7)) begin
        errors++; $display("FAIL press_latency cycle=%0d got=%b want=%b", k, reg_user_en, (k == 7));
      end
    end
    tick(3); raw[0] = 1'b0;
    stt_using = 1'b1; tick(1); stt_using = 1'b0; tick(8);
    checks++;
    if (obs !== m_exp) begin errors++; $display("FAIL debounce_model got=%b want=%b", obs, m_exp); end
  endtask

  task automatic test_handshake;
    int k = 0;
    stt_ready = 1'b1; stt_using = 1'b0; raw[0] = 1'b1;
    while (reg_user_en !== 1'b1 && k < 20) begin tick(1); k++; end
    checks++;
    if (reg_user_en !== 1'b1) begin errors++; $display("FAIL hs_user_req got=%b want=1", reg_user_en); end
    raw[0] = 1'b0; stt_using = 1'b1; stt_ready = 1'b0;
    tick(1);
    checks++;
    if (reg_user_en !== 1'b0) begin errors++; $display("FAIL hs_user_drop got=%b want=0", reg_user_en); end
    raw[1] = 1'b1; k = 0;
    while (reg_spray_en !== 1'b1 && k < 20) begin tick(1); k++; end
    checks++;
    if (k != 7) begin errors++; $display("FAIL hs_spray_latency got=%0d want=7", k); end
    raw[1] = 1'b0; tick(8); raw[1] = 1'b1; tick(8); raw[1] = 1'b0; tick(8);
    checks++;
    if (reg_spray_en !== 1'b1) begin errors++; $display("FAIL hs_spray_hold got=%b want=1", reg_spray_en); end
    stt_using = 1'b0; tick(1);
    checks++;
    if (reg_spray_en !== 1'b0) begin errors++; $display("FAIL hs_spray_release got=%b want=0", reg_spray_en); end
    stt_ready = 1'b1; raw[1] = 1'b1; k = 0;
    for (int j = 0; j < 10; j++) begin tick(1); if (reg_spray_en !== 1'b0) k++; end
    checks++;
    if (k != 0) begin errors++; $display("FAIL spray_ignored_idle high_cycles=%0d want=0", k); end
    raw[1] = 1'b0; tick(8);
    checks++;
    if (obs !== m_exp) begin errors++; $display("FAIL hs_model got=%b want=%b", obs, m_exp); end
  endtask

  task automatic test_timeout;
    int k = 0, n = 0;
    logic last_ce = 1'b0;
    stt_ready = 1'b1; stt_using = 1'b0; raw[0] = 1'b1;
    while (reg_user_en !== 1'b1 && k < 20) begin tick(1); k++; end
    raw[0] = 1'b0;
`ifdef USER_TIMEOUT_EN
    for (int j = 0; j < 80; j++) begin
      if (reg_user_en !== 1'b1) break;
      last_ce = ce;
      if (ce === 1'b1) n++;
      tick(1);
    end
    checks++;
    if (n != P_TO || last_ce !== 1'b1 || reg_user_en !== 1'b0) begin
      errors++; $display("FAIL timeout ce_seen=%0d last_ce=%b user_en=%b want 3/1/0", n, last_ce, reg_user_en);
    end
`else
    for (int j = 0; j < 100; j++) begin tick(1); if (reg_user_en !== 1'b1) n++; if (ce === 1'b1) last_ce = 1'b1; end
    checks++;
    if (n != 0 || last_ce !== 1'b1) begin
      errors++; $display("FAIL no_timeout low_cycles=%0d ce_seen=%b want 0/1", n, last_ce);
    end
    stt_using = 1'b1; tick(1); stt_using = 1'b0; tick(1);
`endif
    checks++;
    if (obs !== m_exp) begin errors++; $display("FAIL timeout_model got=%b want=%b", obs, m_exp); end
  endtask

  task automatic test_config;
    logic [3:0] v;
    stt_ready = 1'b1; raw[4] = 1'b1; tick(8);
    checks++;
    if (reg_spray_mode !== 1'b1) begin errors++; $display("FAIL cfg_load got=%b want=1", reg_spray_mode); end
    stt_ready = 1'b0; raw[4] = 1'b0; tick(10);
    checks++;
    if (reg_spray_mode !== 1'b1) begin errors++; $display("FAIL cfg_freeze got=%b want=1", reg_spray_mode); end
    stt_ready = 1'b1; tick(1);
    checks++;
    if (reg_spray_mode !== 1'b0) begin errors++; $display("FAIL cfg_update got=%b want=0", reg_spray_mode); end
    for (int j = 0; j < 4; j++) begin
      v = 4'($urandom);
      raw[6:3] = v; tick(8);
      checks++;
      if (obs_cfg !== v) begin errors++; $display("FAIL cfg_pattern got=%b want=%b", obs_cfg, v); end
    end
  endtask

  task automatic test_reset_mid_flush;
    int k = 0;
    stt_ready = 1'b1; stt_using = 1'b0; raw[2] = 1'b1; raw[0] = 1'b1;
    while (reg_user_en !== 1'b1 && k < 20) begin tick(1); k++; end
    raw[0] = 1'b0; stt_using = 1'b1; stt_ready = 1'b0; tick(1);
    raw[1] = 1'b1; k = 0;
    while (reg_spray_en !== 1'b1 && k < 20) begin tick(1); k++; end
    raw[1] = 1'b0;
    checks++;
    if ({reg_spray_en, reg_wash_using} !== 2'b11) begin
      errors++; $display("FAIL flush_reached got=%b want=11", {reg_spray_en, reg_wash_using});
    end
    reset = 1'b1; tick(1);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_mid_flush got=%b want=%b", obs, 8'h00); end
    reset = 1'b0; k = 0;
    while (ce !== 1'b1 && k < 30) begin
      tick(1); k++;
      if (reg_spray_en !== 1'b0) begin errors++; checks++; $display("FAIL post_reset_spray got=1 want=0"); end
    end
    checks++;
    if (k != P_CE) begin errors++; $display("FAIL post_reset_ce got=%0d want=%0d", k, P_CE); end
    stt_using = 1'b0; raw[2] = 1'b0; tick(8);
  endtask

  task automatic test_random;
    for (int c = 0; c < 1500; c++) begin
      tick(1);
      checks++;
      if (obs !== m_exp) begin errors++; $display("FAIL random cycle=%0d got=%b want=%b", c, obs, m_exp); end
      for (int i = 0; i < 7; i++) if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 15) == 0) stt_ready = ~stt_ready;
      if ($urandom_range(0, 15) == 0) stt_using = ~stt_using;
    end
  endtask

  initial begin
    test_reset;
    test_ce;
    test_debounce;
    test_handshake;
    test_timeout;
    test_config;
    test_reset_mid_flush;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
